// File: rtl/toggle_gen_pkg.sv
// Shared encodings for the toggle pattern generator: pattern modes and FSM states.
package toggle_gen_pkg;

  typedef enum logic [1:0] {
    MODE_ALL    = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SINGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/toggle_interval_timer.sv
// Interval down-counter: load has priority, enable decrements, expired flags a zero count.
module toggle_interval_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Decrement stops at zero so an idle enable can never wrap the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/toggle_pattern_generator.sv
// Generates timed toggle sequences on pattern_out to exercise a downstream toggle detector.
module toggle_pattern_generator
  import toggle_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] interval,
  input  logic [CNT_W-1:0] num_toggles,
  output logic [WIDTH-1:0] pattern_out,
  output logic             toggle_strobe,
  output logic [CNT_W-1:0] toggle_count,
  output logic             busy,
  output logic             done
);

  state_e           state;
  state_e           next_state;
  mode_e            mode_q;
  logic [CNT_W-1:0] reload_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] first_reload;
  logic [CNT_W-1:0] timer_value;
  logic             launch;
  logic             evt;
  logic             expired;
  logic             timer_load;
  logic             timer_en;

  function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      MODE_WALK:  s[0] = 1'b1;
      MODE_CHECK: for (int i = 0; i < WIDTH; i += 2) s[i] = 1'b1;
      default:    s = '0;
    endcase
    return s;
  endfunction

  // Rotation written as two shifts so it also holds for a 1-bit bus.
  function automatic logic [WIDTH-1:0] next_of(input logic [WIDTH-1:0] p, input mode_e m);
    logic [WIDTH-1:0] n;
    case (m)
      MODE_WALK:   n = (p << 1) | (p >> (WIDTH - 1));
      MODE_SINGLE: n = p ^ WIDTH'(1);
      default:     n = ~p;
    endcase
    return n;
  endfunction

  assign first_reload = (interval == '0) ? '0 : interval - 1'b1;
  assign launch       = (state == IDLE) && start;

  // Stop outranks completion and timer expiry; a reached count ends the run without an event.
  always_comb begin
    next_state = state;
    evt        = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (stop) begin
          next_state = IDLE;
        end else if (toggle_count == num_q) begin
          next_state = DONE;
        end else if (expired) begin
          evt = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign timer_load  = launch || evt;
  assign timer_value = launch ? first_reload : reload_q;
  assign timer_en    = (state == RUN) && !evt;

  toggle_interval_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_en),
    .expired    (expired)
  );

  // Configuration is captured once per sequence; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (launch) begin
      mode_q   <= mode_e'(mode);
      reload_q <= first_reload;
      num_q    <= num_toggles;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_out   <= '0;
      toggle_count  <= '0;
      toggle_strobe <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (launch) begin
        pattern_out  <= seed_of(mode_e'(mode));
        toggle_count <= '0;
      end else if (evt) begin
        pattern_out  <= next_of(pattern_out, mode_q);
        toggle_count <= toggle_count + 1'b1;
      end
      toggle_strobe <= evt;
      busy          <= (next_state == RUN);
      done          <= (state == RUN) && (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_toggle_pattern_generator.sv
// Directed scoreboard bench for toggle_pattern_generator (8-bit and 1-bit instances).
module tb_toggle_pattern_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop;
  logic [1:0]  mode;
  logic [15:0] interval, num_toggles;
  logic [7:0]  pattern_out;
  logic        toggle_strobe;
  logic [15:0] toggle_count;
  logic        busy, done;

  logic        start_w1;
  logic [0:0]  pattern_w1;
  logic        strobe_w1;
  logic [15:0] count_w1;
  logic        busy_w1, done_w1;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [7:0]  pat;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          det_en = 1'b0;
  logic [7:0]  prev_pat = '0;
  logic        prev_busy = 1'b0;

  toggle_pattern_generator #(.WIDTH(8), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .interval      (interval),
    .num_toggles   (num_toggles),
    .pattern_out   (pattern_out),
    .toggle_strobe (toggle_strobe),
    .toggle_count  (toggle_count),
    .busy          (busy),
    .done          (done)
  );

  toggle_pattern_generator #(.WIDTH(1), .CNT_W(16)) dut_w1 (
    .clk           (clk),
    .reset         (reset),
    .start         (start_w1),
    .stop          (1'b0),
    .mode          (2'd1),
    .interval      (16'd1),
    .num_toggles   (16'd3),
    .pattern_out   (pattern_w1),
    .toggle_strobe (strobe_w1),
    .toggle_count  (count_w1),
    .busy          (busy_w1),
    .done          (done_w1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor plus loopback detector (flag = pattern differs from previous cycle).
  always @(negedge clk) begin
    exp_t e;
    logic flag;
    if (!reset && (toggle_strobe || done)) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output cyc=%0d strobe=%0b done=%0b pattern=%h count=%0d, required no output",
                 cyc, toggle_strobe, done, pattern_out, toggle_count);
      end else begin
        e = sbq.pop_front();
        if (done !== e.is_done || toggle_strobe !== !e.is_done || cyc != e.cyc ||
            pattern_out !== e.pat || toggle_count !== e.cnt) begin
          n_fail++;
          $display("FAIL scoreboard got cyc=%0d done=%0b pattern=%h count=%0d, required cyc=%0d done=%0b pattern=%h count=%0d",
                   cyc, done, pattern_out, toggle_count, e.cyc, e.is_done, e.pat, e.cnt);
        end
      end
    end
    if (det_en && prev_busy) begin
      flag = (pattern_out !== prev_pat);
      n_tests++;
      if (flag !== toggle_strobe) begin
        n_fail++;
        $display("FAIL detector cyc=%0d flag=%0b, required strobe=%0b", cyc, flag, toggle_strobe);
      end
    end
    prev_pat  = pattern_out;
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %h, required %h", nm, act, req);
    end
  endtask

  task automatic push_ev(input int c, input logic [7:0] p, input logic [15:0] n);
    exp_t e;
    e = '{1'b0, c, p, n};
    sbq.push_back(e);
  endtask

  task automatic push_done(input int c, input logic [7:0] p, input logic [15:0] n);
    exp_t e;
    e = '{1'b1, c, p, n};
    sbq.push_back(e);
  endtask

  task automatic go(input logic [1:0] m, input logic [15:0] iv, input logic [15:0] n);
    mode        = m;
    interval    = iv;
    num_toggles = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while ((busy || done) && k < max_cycles) begin
      tick();
      k++;
    end
    n_tests++;
    if (busy || done) begin
      n_fail++;
      $display("FAIL wait_idle timeout busy=%0b done=%0b, required idle within %0d cycles", busy, done, max_cycles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int strobes;
    int dones;
    logic [7:0] walk [9];
    walk = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

    reset = 1'b1; start = 1'b0; stop = 1'b0; start_w1 = 1'b0;
    mode = 2'd0; interval = '0; num_toggles = '0;

    // Reset state before any clock edge.
    #2;
    check("reset_pattern", pattern_out, 0);
    check("reset_count", toggle_count, 0);
    check("reset_busy_done_strobe", {busy, done, toggle_strobe}, 0);
    tick(); tick(); tick();
    reset  = 1'b0;
    det_en = 1'b1;

    // Mode 0, interval 3, four events, start in cycle 10; input changes and start mid-run ignored.
    while (cyc < 10) tick();
    push_ev(14, 8'hFF, 1); push_ev(17, 8'h00, 2); push_ev(20, 8'hFF, 3); push_ev(23, 8'h00, 4);
    push_done(24, 8'h00, 4);
    go(2'd0, 16'd3, 16'd4);
    check("m0_seed_cycle", cyc, 11);
    check("m0_seed", {busy, toggle_strobe, pattern_out}, {1'b1, 1'b0, 8'h00});
    mode = 2'd2; interval = 16'd7; num_toggles = 16'd1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(40);
    check("m0_final_count", toggle_count, 4);

    // Mode 1, interval 0: walking one every cycle.
    tick();
    s = cyc;
    for (int k = 0; k < 9; k++) push_ev(s + 2 + k, walk[k], 16'(k + 1));
    push_done(s + 11, 8'h02, 9);
    go(2'd1, 16'd0, 16'd9);
    check("m1_seed", {busy, pattern_out}, {1'b1, 8'h01});
    wait_idle(30);

    // Mode 2, interval 2: stop coincides with expiry of event 3.
    tick();
    s = cyc;
    push_ev(s + 3, 8'hAA, 1); push_ev(s + 5, 8'h55, 2);
    go(2'd2, 16'd2, 16'd5);
    check("m2_seed", pattern_out, 8'h55);
    while (cyc < s + 6) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy_done_strobe", {busy, done, toggle_strobe}, 0);
    check("stop_count", toggle_count, 2);
    check("stop_pattern", pattern_out, 8'h55);
    tick(); tick(); tick();
    check("idle_hold", {toggle_count, pattern_out}, {16'd2, 8'h55});

    // num_toggles = 0: one RUN cycle with the seed, then done, no strobe.
    s = cyc;
    push_done(s + 2, 8'h00, 0);
    go(2'd0, 16'd5, 16'd0);
    check("n0_seed", {busy, toggle_strobe, pattern_out}, {1'b1, 1'b0, 8'h00});
    wait_idle(10);

    // Mode 2 again with interval 1 for loopback coverage.
    tick();
    s = cyc;
    push_ev(s + 2, 8'hAA, 1); push_ev(s + 3, 8'h55, 2); push_ev(s + 4, 8'hAA, 3);
    push_done(s + 5, 8'hAA, 3);
    go(2'd2, 16'd1, 16'd3);
    wait_idle(20);

    // Reset mid-run right after event 2 of 10.
    tick();
    s = cyc;
    push_ev(s + 3, 8'hFF, 1); push_ev(s + 5, 8'h00, 2);
    go(2'd0, 16'd2, 16'd10);
    while (cyc < s + 5) tick();
    @(negedge clk);
    #1;
    det_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("async_reset_pattern", pattern_out, 0);
    check("async_reset_count", toggle_count, 0);
    check("async_reset_ctrl", {busy, done, toggle_strobe}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    det_en = 1'b1;
    s = cyc;
    push_ev(s + 2, 8'h01, 1); push_ev(s + 3, 8'h00, 2);
    push_done(s + 4, 8'h00, 2);
    go(2'd3, 16'd1, 16'd2);
    check("restart_seed", {busy, pattern_out}, {1'b1, 8'h00});
    wait_idle(20);

    // WIDTH=1 walking one: strobes counted, pattern never changes.
    strobes = 0;
    dones   = 0;
    start_w1 = 1'b1;
    tick();
    start_w1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy_w1 || done_w1) check("w1_pattern_static", pattern_w1, 1);
      if (strobe_w1) strobes++;
      if (done_w1) dones++;
      tick();
    end
    check("w1_strobes", strobes, 3);
    check("w1_count", count_w1, 3);
    check("w1_done", dones, 1);

    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
